// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore sequencing FSM plus ALU decoder.
// All outputs are combinational from the current state, op, funct and zero.
module mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic [3:0] state
);

   localparam int unsigned OP_W    = 6;
   localparam int unsigned STATE_W = 4;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
   localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
   localparam logic [OP_W-1:0] FN_AND = 6'b100100;
   localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
   localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic       w_pcwrite;
   logic       w_branch;
   logic       w_irwrite;
   logic       w_memwrite;
   logic       w_regwrite;
   logic [1:0] w_aluop;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   // Next-state logic; op only matters in DECODE and MEMADR
   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:   w_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE:     w_next = S_EXECUTE;
               OP_BEQ:       w_next = S_BRANCH;
               OP_ADDI:      w_next = S_ADDIEX;
               OP_J:         w_next = S_JUMP;
               default:      w_next = S_FETCH;
            endcase
         end
         S_MEMADR:  w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   w_next = S_MEMWB;
         S_EXECUTE: w_next = S_ALUWB;
         S_ADDIEX:  w_next = S_ADDIWB;
         default:   w_next = S_FETCH;
      endcase
   end

   // Per-state control decode
   always_comb begin
      w_pcwrite  = 1'b0;
      w_branch   = 1'b0;
      w_irwrite  = 1'b0;
      w_memwrite = 1'b0;
      w_regwrite = 1'b0;
      w_aluop    = 2'b00;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      case (r_state)
         S_FETCH: begin
            w_irwrite = 1'b1;
            w_pcwrite = 1'b1;
            alusrcb   = 2'b01;
         end
         S_DECODE: alusrcb = 2'b11;
         S_MEMADR, S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWB: begin
            memtoreg   = 1'b1;
            w_regwrite = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            w_memwrite = 1'b1;
         end
         S_EXECUTE: begin
            alusrca = 1'b1;
            w_aluop = 2'b10;
         end
         S_ALUWB: begin
            regdst     = 1'b1;
            w_regwrite = 1'b1;
         end
         S_ADDIWB: w_regwrite = 1'b1;
         S_BRANCH: begin
            alusrca  = 1'b1;
            w_aluop  = 2'b01;
            pcsrc    = 2'b01;
            w_branch = 1'b1;
         end
         S_JUMP: begin
            pcsrc     = 2'b10;
            w_pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   // ALU decoder; unknown funct and aluop 11 fall back to add
   always_comb begin
      alucontrol = ALU_ADD;
      case (w_aluop)
         2'b01: alucontrol = ALU_SUB;
         2'b10: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

   // Architectural write enables are suppressed for the whole reset cycle
   assign pcen     = ~reset & (w_pcwrite | (w_branch & zero));
   assign irwrite  = ~reset & w_irwrite;
   assign memwrite = ~reset & w_memwrite;
   assign regwrite = ~reset & w_regwrite;
   assign state    = STATE_W'(r_state);

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through the FSM
// and checks state and control outputs one time unit after each rising edge.
module tb_mc_controller;

   logic       clk;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;

   int n_checks = 0;
   int n_err    = 0;

   mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
      .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [5:0] fn_tab [6];
   logic [2:0] ac_tab [6];

   initial begin
      fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
      ac_tab = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};

      reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;

      // reset held two cycles
      tick(); tick();
      chk("rst_state",   state,             4'd0);
      chk("rst_pcen",    4'(pcen),          4'd0);
      chk("rst_irwrite", 4'(irwrite),       4'd0);
      chk("rst_alusrcb", 4'(alusrcb),       4'd1);
      chk("rst_aluctl",  4'(alucontrol),    4'd2);
      reset = 1'b0;
      #1;
      chk("fetch_pcen",    4'(pcen),    4'd1);
      chk("fetch_irwrite", 4'(irwrite), 4'd1);
      chk("fetch_alusrcb", 4'(alusrcb), 4'd1);
      chk("fetch_aluctl",  4'(alucontrol), 4'd2);

      // lw: 0,1,2,3,4,0
      op = 6'b100011;
      tick(); chk("lw_s1", state, 4'd1);
      chk("dec_alusrcb", 4'(alusrcb), 4'd3);
      chk("dec_pcen",    4'(pcen),    4'd0);
      tick(); chk("lw_s2", state, 4'd2);
      chk("madr_alusrca", 4'(alusrca), 4'd1);
      chk("madr_alusrcb", 4'(alusrcb), 4'd2);
      tick(); chk("lw_s3", state, 4'd3);
      chk("memrd_iord", 4'(iord), 4'd1);
      tick(); chk("lw_s4", state, 4'd4);
      chk("memwb_memtoreg", 4'(memtoreg), 4'd1);
      chk("memwb_regwrite", 4'(regwrite), 4'd1);
      chk("memwb_regdst",   4'(regdst),   4'd0);
      tick(); chk("lw_s0", state, 4'd0);

      // sw: 0,1,2,5,0
      op = 6'b101011;
      tick(); chk("sw_s1", state, 4'd1);
      tick(); chk("sw_s2", state, 4'd2);
      chk("sw_madr_memwrite", 4'(memwrite), 4'd0);
      tick(); chk("sw_s5", state, 4'd5);
      chk("memwr_memwrite", 4'(memwrite), 4'd1);
      chk("memwr_iord",     4'(iord),     4'd1);
      chk("memwr_regwrite", 4'(regwrite), 4'd0);
      tick(); chk("sw_s0", state, 4'd0);
      chk("sw_end_memwrite", 4'(memwrite), 4'd0);

      // R-type across functs
      op = 6'b000000;
      for (int i = 0; i < 6; i++) begin
         funct = fn_tab[i];
         tick(); chk("r_s1", state, 4'd1);
         tick(); chk("r_s6", state, 4'd6);
         chk("r_aluctl",  4'(alucontrol), 4'(ac_tab[i]));
         chk("r_alusrcb", 4'(alusrcb),    4'd0);
         tick(); chk("r_s7", state, 4'd7);
         chk("aluwb_regdst",   4'(regdst),   4'd1);
         chk("aluwb_regwrite", 4'(regwrite), 4'd1);
         tick(); chk("r_s0", state, 4'd0);
      end

      // beq, zero toggled within BRANCH
      op = 6'b000100; funct = 6'b100101;
      tick(); chk("beq_s1", state, 4'd1);
      tick(); chk("beq_s8", state, 4'd8);
      zero = 1'b1; #1;
      chk("beq_taken_pcen", 4'(pcen),       4'd1);
      chk("beq_pcsrc",      4'(pcsrc),      4'd1);
      chk("beq_aluctl",     4'(alucontrol), 4'd6);
      zero = 1'b0; #1;
      chk("beq_nt_pcen",    4'(pcen),       4'd0);
      tick(); chk("beq_s0", state, 4'd0);

      // j
      op = 6'b000010;
      tick(); chk("j_s1", state, 4'd1);
      tick(); chk("j_s11", state, 4'd11);
      chk("j_pcen",  4'(pcen),  4'd1);
      chk("j_pcsrc", 4'(pcsrc), 4'd2);
      tick(); chk("j_s0", state, 4'd0);

      // addi: 0,1,9,10,0
      op = 6'b001000;
      tick(); chk("addi_s1", state, 4'd1);
      tick(); chk("addi_s9", state, 4'd9);
      chk("addiex_alusrcb", 4'(alusrcb), 4'd2);
      tick(); chk("addi_s10", state, 4'd10);
      chk("addiwb_regwrite", 4'(regwrite), 4'd1);
      chk("addiwb_regdst",   4'(regdst),   4'd0);
      tick(); chk("addi_s0", state, 4'd0);

      // unrecognised op
      op = 6'b111111;
      tick(); chk("bad_s1", state, 4'd1);
      chk("bad_regwrite", 4'(regwrite), 4'd0);
      chk("bad_memwrite", 4'(memwrite), 4'd0);
      tick(); chk("bad_s0", state, 4'd0);

      // reset during MEMWR
      op = 6'b101011;
      tick(); tick(); tick();
      chk("rstwr_s5", state, 4'd5);
      reset = 1'b1; #1;
      chk("rstwr_memwrite", 4'(memwrite), 4'd0);
      tick();
      chk("rstwr_s0", state, 4'd0);
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
